// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer and its decoder.
// Latency: n/a (constants, types only).
// Backpressure: n/a.
// Contents: opcode/funct constants, ALU select encodings, FSM state enum, R-type field layout.
package instr_sequencer_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_NOR = 6'h27;

    // ALU select encodings, shared with the ALU.
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_DECODE,
        ST_EXEC,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } rtype_t;

endpackage

// File: rtl/instr_sequencer_decoder.sv
// Combinational R-type decoder: splits fields and maps funct to an ALU select.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: instr in; rs/rt/rd register addresses, selec ALU op, is_halt, is_illegal out.
module instr_decoder
    import instr_sequencer_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [3:0]  selec,
    output logic        is_halt,
    output logic        is_illegal
);

    rtype_t f;
    logic   funct_known;
    logic   unused_shamt;

    assign f            = rtype_t'(instr);
    assign rs           = f.rs;
    assign rt           = f.rt;
    assign rd           = f.rd;
    assign unused_shamt = ^f.shamt;

    always_comb begin
        selec       = ALU_AND;
        funct_known = 1'b1;
        case (f.funct)
            FN_AND:  selec = ALU_AND;
            FN_OR:   selec = ALU_OR;
            FN_ADD:  selec = ALU_ADD;
            FN_SUB:  selec = ALU_SUB;
            FN_SLT:  selec = ALU_SLT;
            FN_NOR:  selec = ALU_NOR;
            default: funct_known = 1'b0;
        endcase
    end

    // HALT takes priority so its funct field is never inspected.
    assign is_halt    = (f.opcode == OP_HALT);
    assign is_illegal = !is_halt && ((f.opcode != OP_RTYPE) || !funct_known);

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer driving the register-bank/ALU datapath from a sync instruction memory.
// Latency: 4 cycles per instruction (FETCH, WAIT, DECODE, EXEC); wr_en on the 4th cycle.
// Backpressure: none; memory must return data one cycle after imem_rd_en, start ignored while busy.
// Ports: clk/rst/start in; imem_addr/imem_rd_en out, imem_data in; dir1/dir2/dir_es/selec/wr_en to datapath;
//        busy/done/illegal/instr_count status.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd_en,
    input  logic [31:0]       imem_data,
    output logic [4:0]        dir1,
    output logic [4:0]        dir2,
    output logic [4:0]        dir_es,
    output logic [3:0]        selec,
    output logic              wr_en,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic [CNT_W-1:0]  instr_count
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [4:0]        dir1_q, dir1_d;
    logic [4:0]        dir2_q, dir2_d;
    logic [4:0]        dir_es_q, dir_es_d;
    logic [3:0]        selec_q, selec_d;
    logic              illegal_q, illegal_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [4:0] dec_rs, dec_rt, dec_rd;
    logic [3:0] dec_selec;
    logic       dec_halt, dec_illegal;

    instr_decoder u_decoder (
        .instr      (ir_q),
        .rs         (dec_rs),
        .rt         (dec_rt),
        .rd         (dec_rd),
        .selec      (dec_selec),
        .is_halt    (dec_halt),
        .is_illegal (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            dir1_q    <= '0;
            dir2_q    <= '0;
            dir_es_q  <= '0;
            selec_q   <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            dir1_q    <= dir1_d;
            dir2_q    <= dir2_d;
            dir_es_q  <= dir_es_d;
            selec_q   <= selec_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        dir1_d    = dir1_q;
        dir2_d    = dir2_q;
        dir_es_d  = dir_es_q;
        selec_d   = selec_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    pc_d      = '0;
                    cnt_d     = '0;
                    illegal_d = 1'b0;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                ir_d    = imem_data;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (dec_halt) begin
                    illegal_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (dec_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    // Datapath addresses only move here, so they are stable through EXEC.
                    dir1_d   = dec_rs;
                    dir2_d   = dec_rt;
                    dir_es_d = dec_rd;
                    selec_d  = dec_selec;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Running off the end of memory stops rather than wrapping to 0.
                if (pc_q == '1) begin
                    state_d = ST_DONE;
                end else begin
                    pc_d    = pc_q + 1'b1;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_rd_en = (state_q == ST_FETCH);
        // Writes to r0 are suppressed but the instruction still retires.
        wr_en      = (state_q == ST_EXEC) && (dir_es_q != 5'd0);
        busy       = (state_q == ST_FETCH) || (state_q == ST_WAIT) ||
                     (state_q == ST_DECODE) || (state_q == ST_EXEC);
        done       = (state_q == ST_DONE);
    end

    assign imem_addr   = pc_q;
    assign dir1        = dir1_q;
    assign dir2        = dir2_q;
    assign dir_es      = dir_es_q;
    assign selec       = selec_q;
    assign illegal     = illegal_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: full-size instance plus an ADDR_W=2 instance for the no-wrap case.
// Latency: expectations are placed at fixed cycle offsets from each start pulse.
// Backpressure: n/a; memories are behavioural one-cycle synchronous reads.
module tb_instr_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance, ADDR_W = 8.
    logic        start = 1'b0;
    logic [7:0]  imem_addr;
    logic        imem_rd_en;
    logic [31:0] imem_data;
    logic [4:0]  dir1, dir2, dir_es;
    logic [3:0]  selec;
    logic        wr_en, busy, done, illegal;
    logic [15:0] instr_count;

    // Small instance, ADDR_W = 2.
    logic        start2 = 1'b0;
    logic [1:0]  imem_addr2;
    logic        imem_rd_en2;
    logic [31:0] imem_data2;
    logic [4:0]  dir1_2, dir2_2, dir_es2;
    logic [3:0]  selec2;
    logic        wr_en2, busy2, done2, illegal2;
    logic [15:0] instr_count2;

    logic [31:0] mem  [256];
    logic [31:0] mem2 [4];

    always @(posedge clk) if (imem_rd_en)  imem_data  <= mem[imem_addr];
    always @(posedge clk) if (imem_rd_en2) imem_data2 <= mem2[imem_addr2];

    int wr_seen  = 0;
    int wr_seen2 = 0;
    always @(posedge clk) if (wr_en)  wr_seen  <= wr_seen + 1;
    always @(posedge clk) if (wr_en2) wr_seen2 <= wr_seen2 + 1;

    instr_sequencer #(.ADDR_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_data(imem_data),
        .dir1(dir1), .dir2(dir2), .dir_es(dir_es), .selec(selec), .wr_en(wr_en),
        .busy(busy), .done(done), .illegal(illegal), .instr_count(instr_count)
    );

    instr_sequencer #(.ADDR_W(2), .CNT_W(16)) dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .imem_addr(imem_addr2), .imem_rd_en(imem_rd_en2), .imem_data(imem_data2),
        .dir1(dir1_2), .dir2(dir2_2), .dir_es(dir_es2), .selec(selec2), .wr_en(wr_en2),
        .busy(busy2), .done(done2), .illegal(illegal2), .instr_count(instr_count2)
    );

    int vectors     = 0;
    int miscompares = 0;
    int base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive start for one cycle; returns at the negedge of the first FETCH cycle.
    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
        logic [31:0] w;
        w = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
        return w;
    endfunction

    localparam logic [31:0] HALT = 32'hFC00_0000;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = HALT;
        for (int i = 0; i < 4; i++)   mem2[i] = rtype(1, 2, i + 1, 6'h20);

        // ---- reset state ----
        cyc(3);
        rst = 1'b0;
        chk("rst_busy",   busy, 0);
        chk("rst_done",   done, 0);
        chk("rst_wr_en",  wr_en, 0);
        chk("rst_rd_en",  imem_rd_en, 0);
        chk("rst_addr",   imem_addr, 0);
        chk("rst_dirs",   {dir1, dir2, dir_es, selec}, 0);
        chk("rst_count",  instr_count, 0);
        chk("rst_illegal", illegal, 0);

        // ---- single ADD then HALT ----
        mem[0] = 32'h0022_1820;
        mem[1] = HALT;
        base = wr_seen;
        pulse_start();
        chk("t1_fetch_rd_en", imem_rd_en, 1);
        chk("t1_fetch_busy",  busy, 1);
        cyc(3);
        chk("t1_wr_en",  wr_en, 1);
        chk("t1_dir1",   dir1, 1);
        chk("t1_dir2",   dir2, 2);
        chk("t1_dir_es", dir_es, 3);
        chk("t1_selec",  selec, 4'b0010);
        cyc(1);
        chk("t1_fetch2_addr", imem_addr, 1);
        chk("t1_hold_dir_es", dir_es, 3);
        cyc(3);
        chk("t1_done",    done, 1);
        chk("t1_busy",    busy, 0);
        chk("t1_count",   instr_count, 1);
        chk("t1_illegal", illegal, 0);
        chk("t1_pulses",  wr_seen - base, 1);

        // ---- six ops then HALT, one EXEC every 4 cycles ----
        mem[0] = rtype(1, 2, 3, 6'h24);
        mem[1] = rtype(4, 5, 6, 6'h25);
        mem[2] = rtype(7, 8, 9, 6'h20);
        mem[3] = rtype(10, 11, 12, 6'h22);
        mem[4] = rtype(13, 14, 15, 6'h2A);
        mem[5] = rtype(16, 17, 18, 6'h27);
        mem[6] = HALT;
        base = wr_seen;
        pulse_start();
        chk("t2_restart_count", instr_count, 0);
        cyc(3);
        chk("t2_and_sel", selec, 4'b0000);
        chk("t2_and_wr",  wr_en, 1);
        chk("t2_and_rd",  dir_es, 3);
        cyc(4);
        chk("t2_or_sel",  selec, 4'b0001);
        chk("t2_or_wr",   wr_en, 1);
        chk("t2_or_rs",   dir1, 4);
        cyc(4);
        chk("t2_add_sel", selec, 4'b0010);
        chk("t2_add_wr",  wr_en, 1);
        cyc(4);
        chk("t2_sub_sel", selec, 4'b0110);
        chk("t2_sub_wr",  wr_en, 1);
        chk("t2_sub_rt",  dir2, 11);
        cyc(4);
        chk("t2_slt_sel", selec, 4'b0111);
        chk("t2_slt_wr",  wr_en, 1);
        cyc(4);
        chk("t2_nor_sel", selec, 4'b1100);
        chk("t2_nor_wr",  wr_en, 1);
        chk("t2_nor_rd",  dir_es, 18);
        cyc(4);
        chk("t2_done",   done, 1);
        chk("t2_count",  instr_count, 6);
        chk("t2_pulses", wr_seen - base, 6);

        // ---- unsupported funct after one good instruction ----
        mem[0] = rtype(1, 2, 4, 6'h20);
        mem[1] = rtype(1, 2, 5, 6'h3B);
        mem[2] = HALT;
        base = wr_seen;
        pulse_start();
        cyc(3);
        chk("t3_exec_wr", wr_en, 1);
        cyc(4);
        chk("t3_done",    done, 1);
        chk("t3_illegal", illegal, 1);
        chk("t3_count",   instr_count, 1);
        chk("t3_hold_rd", dir_es, 4);
        chk("t3_pulses",  wr_seen - base, 1);
        cyc(2);
        chk("t3_done_holds", done, 1);

        // ---- non-R-type opcode as first instruction ----
        mem[0] = 32'h2022_1820;
        base = wr_seen;
        pulse_start();
        chk("t3b_illegal_cleared", illegal, 0);
        cyc(3);
        chk("t3b_done",    done, 1);
        chk("t3b_illegal", illegal, 1);
        chk("t3b_count",   instr_count, 0);
        chk("t3b_pulses",  wr_seen - base, 0);

        // ---- write to r0 retires without a write ----
        mem[0] = 32'h0022_0020;
        mem[1] = HALT;
        base = wr_seen;
        pulse_start();
        cyc(3);
        chk("t4_dir_es", dir_es, 0);
        chk("t4_wr_en",  wr_en, 0);
        chk("t4_busy",   busy, 1);
        cyc(4);
        chk("t4_done",    done, 1);
        chk("t4_count",   instr_count, 1);
        chk("t4_illegal", illegal, 0);
        chk("t4_pulses",  wr_seen - base, 0);

        // ---- ADDR_W=2, no HALT: stops after address 3 ----
        start2 = 1'b1;
        cyc(1);
        start2 = 1'b0;
        cyc(3);
        chk("t5_exec0_rd", dir_es2, 1);
        chk("t5_exec0_wr", wr_en2, 1);
        cyc(4);
        chk("t5_exec1_rd", dir_es2, 2);
        cyc(4);
        chk("t5_exec2_rd", dir_es2, 3);
        cyc(4);
        chk("t5_exec3_rd", dir_es2, 4);
        chk("t5_exec3_addr", imem_addr2, 3);
        cyc(1);
        chk("t5_done",    done2, 1);
        chk("t5_illegal", illegal2, 0);
        chk("t5_count",   instr_count2, 4);
        chk("t5_addr",    imem_addr2, 3);
        cyc(4);
        chk("t5_no_wrap_rd_en", imem_rd_en2, 0);
        chk("t5_still_done",    done2, 1);
        chk("t5_pulses",        wr_seen2, 4);

        // ---- reset during WAIT of the second instruction ----
        mem[0] = rtype(1, 2, 3, 6'h20);
        mem[1] = rtype(4, 5, 6, 6'h25);
        mem[2] = HALT;
        base = wr_seen;
        pulse_start();
        cyc(3);
        chk("t6_exec0_wr", wr_en, 1);
        cyc(2);
        chk("t6_wait_busy", busy, 1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("t6_rst_busy",  busy, 0);
        chk("t6_rst_done",  done, 0);
        chk("t6_rst_wr",    wr_en, 0);
        chk("t6_rst_dirs",  {dir1, dir2, dir_es, selec}, 0);
        chk("t6_rst_addr",  imem_addr, 0);
        chk("t6_rst_count", instr_count, 0);
        cyc(4);
        chk("t6_idle_busy",   busy, 0);
        chk("t6_no_extra_wr", wr_en == 1'b0 && (wr_seen - base) == 1, 1);

        // ---- restart; a start pulse while busy is ignored ----
        pulse_start();
        chk("t6_restart_addr", imem_addr, 0);
        cyc(1);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
        chk("t6_re_exec0_rd", dir_es, 3);
        chk("t6_re_exec0_wr", wr_en, 1);
        cyc(4);
        chk("t6_re_exec1_rd",  dir_es, 6);
        chk("t6_re_exec1_sel", selec, 4'b0001);
        cyc(4);
        chk("t6_re_done",  done, 1);
        chk("t6_re_count", instr_count, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
